// File: rtl/seq_det_ctrl.sv
// Programmable serial pattern detector: run-time configured pattern/length,
// valid/ready bit stream, saturating match counter and target-based completion.
module seq_det_ctrl #(
  parameter  int MAXLEN = 8,
  parameter  int CNTW   = 8,
  localparam int LW     = $clog2(MAXLEN + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [MAXLEN-1:0] cfg_pattern,
  input  logic [LW-1:0]     cfg_len,
  input  logic              cfg_overlap,
  input  logic [CNTW-1:0]   cfg_target,
  input  logic              start,
  input  logic              abort,
  input  logic              x_valid,
  input  logic              x,
  output logic              x_ready,
  output logic              match,
  output logic [CNTW-1:0]   match_cnt,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, ARMED, DONE} state_t;

  state_t            state, state_nxt;
  logic [MAXLEN-1:0] pat_q, hist, hist_nxt, mask;
  logic [LW-1:0]     len_q, fill, fill_inc;
  logic              ovl_q, cfg_valid;
  logic [CNTW-1:0]   tgt_q, cnt_inc;
  logic              len_ok, cfg_acc, cfg_rej, start_req, start_ok, start_rej;
  logic              acc, hit, reach;

  assign x_ready = (state == ARMED);
  assign busy    = (state == ARMED);
  assign done    = (state == DONE);

  // NOTE: every signal gets a default at the top of always_comb so no path
  // leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    mask      = '0;
    for (int i = 0; i < MAXLEN; i++) mask[i] = (i < int'(len_q));

    len_ok    = (cfg_len >= LW'(2)) && (cfg_len <= LW'(MAXLEN));
    cfg_acc   = cfg_we && (state != ARMED) && len_ok;
    cfg_rej   = cfg_we && !cfg_acc;
    // Abort has priority over start, so a start in the abort cycle is dropped.
    start_req = start && (state != ARMED) && !abort;
    start_ok  = start_req && (cfg_acc || cfg_valid);
    start_rej = start_req && !start_ok;

    acc       = x_valid && (state == ARMED);
    hist_nxt  = {hist[MAXLEN-2:0], x};
    fill_inc  = (fill == len_q) ? fill : fill + LW'(1);
    // A bit taken in the abort cycle is shifted in but never evaluated.
    hit       = acc && !abort && (fill_inc == len_q) &&
                (((hist_nxt ^ pat_q) & mask) == '0);
    cnt_inc   = (match_cnt == '1) ? match_cnt : match_cnt + CNTW'(1);
    reach     = hit && (tgt_q != '0) && (cnt_inc == tgt_q);

    unique case (state)
      IDLE:    if (start_ok) state_nxt = ARMED;
      ARMED:   if (abort) state_nxt = IDLE;
               else if (reach) state_nxt = DONE;
      DONE:    if (abort) state_nxt = IDLE;
               else if (start_ok) state_nxt = ARMED;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // NOTE: config and history are reset too; a fresh reset must not leave a
  // stale pattern that could arm the detector without a new config write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pat_q     <= '0;
      len_q     <= '0;
      ovl_q     <= 1'b0;
      tgt_q     <= '0;
      cfg_valid <= 1'b0;
      hist      <= '0;
      fill      <= '0;
      match_cnt <= '0;
      match     <= 1'b0;
      err       <= 1'b0;
    end else begin
      err   <= cfg_rej || start_rej;
      match <= hit;
      if (cfg_acc) begin
        pat_q     <= cfg_pattern;
        len_q     <= cfg_len;
        ovl_q     <= cfg_overlap;
        tgt_q     <= cfg_target;
        cfg_valid <= 1'b1;
      end
      if (start_ok) begin
        hist      <= '0;
        fill      <= '0;
        match_cnt <= '0;
      end else if (acc) begin
        hist <= hist_nxt;
        if (hit) begin
          match_cnt <= cnt_inc;
          fill      <= ovl_q ? fill_inc : '0;
        end else begin
          fill      <= fill_inc;
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Directed bench for seq_det_ctrl: hand-computed match timing, counts, done,
// back-pressure, abort, error pulses and async reset.
module tb_seq_det_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_we, cfg_overlap, start, abort, x_valid, x;
  logic [7:0] cfg_pattern, cfg_target;
  logic [3:0] cfg_len;
  logic       x_ready, match, busy, done, err;
  logic [7:0] match_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seq_det_ctrl #(.MAXLEN(8), .CNTW(8)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cfg_target(cfg_target),
    .start(start), .abort(abort), .x_valid(x_valid), .x(x),
    .x_ready(x_ready), .match(match), .match_cnt(match_cnt),
    .busy(busy), .done(done), .err(err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic configure(input logic [7:0] pat, input logic [3:0] len,
                           input logic ovl, input logic [7:0] tgt, input logic go);
    cfg_we = 1'b1; cfg_pattern = pat; cfg_len = len;
    cfg_overlap = ovl; cfg_target = tgt; start = go;
    cycle();
    cfg_we = 1'b0; start = 1'b0;
  endtask

  task automatic send(input logic b);
    x_valid = 1'b1; x = b;
    cycle();
    x_valid = 1'b0;
  endtask

  // Bits go out MSB of the n-bit field first; exp_m holds the expected match
  // pulse seen right after each accept, in the same order.
  task automatic run_stream(input string tag, input logic [15:0] bits, input int n,
                            input logic [15:0] exp_m);
    for (int i = n - 1; i >= 0; i--) begin
      send(bits[i]);
      check($sformatf("%s_match_bit%0d", tag, n - i), match, exp_m[i]);
    end
  endtask

  task automatic do_abort();
    abort = 1'b1;
    cycle();
    abort = 1'b0;
  endtask

  initial begin
    rst = 1'b0; cfg_we = 0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 0;
    cfg_target = '0; start = 0; abort = 0; x_valid = 0; x = 0;
    cycle(); cycle();
    check("rst_busy", busy, 0);
    check("rst_ready", x_ready, 0);
    check("rst_cnt", match_cnt, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_match", match, 0);
    rst = 1'b1;
    cycle();

    // Start with no configuration latched.
    start = 1'b1; cycle(); start = 1'b0;
    check("nocfg_start_err", err, 1);
    check("nocfg_start_busy", busy, 0);
    cycle();
    check("err_is_pulse", err, 0);

    // Illegal length is rejected and leaves config invalid.
    configure(8'b0000_0001, 4'd1, 1'b0, 8'd0, 1'b0);
    check("len1_err", err, 1);
    start = 1'b1; cycle(); start = 1'b0;
    check("len1_cfg_unchanged_err", err, 1);
    check("len1_busy", busy, 0);

    // 7-bit pattern 1101100, write and start together.
    configure(8'b0110_1100, 4'd7, 1'b0, 8'd0, 1'b1);
    check("p7_busy", busy, 1);
    check("p7_ready", x_ready, 1);
    check("p7_err", err, 0);
    run_stream("p7", 16'b1101100, 7, 16'b0000001);
    check("p7_cnt", match_cnt, 1);
    check("p7_still_busy", busy, 1);
    do_abort();
    check("p7_abort_busy", busy, 0);
    check("p7_abort_cnt_held", match_cnt, 1);

    // Overlap on; new config wins over the latched one.
    configure(8'b0000_1011, 4'd4, 1'b1, 8'd0, 1'b1);
    check("ovl_cnt_cleared", match_cnt, 0);
    run_stream("ovl", 16'b1011011, 7, 16'b0001001);
    check("ovl_cnt", match_cnt, 2);
    do_abort();

    // Overlap off: fill restarts after the first match.
    configure(8'b0000_1011, 4'd4, 1'b0, 8'd0, 1'b1);
    run_stream("novl", 16'b1011011, 7, 16'b0001000);
    check("novl_cnt", match_cnt, 1);
    do_abort();

    // Target of two matches.
    configure(8'b0000_1011, 4'd4, 1'b0, 8'd2, 1'b1);
    run_stream("tgt", 16'b10111011, 8, 16'b00010001);
    check("tgt_done", done, 1);
    check("tgt_ready", x_ready, 0);
    check("tgt_busy", busy, 0);
    check("tgt_cnt", match_cnt, 2);
    run_stream("tgt_ignored", 16'b1011, 4, 16'b0000);
    check("tgt_cnt_held", match_cnt, 2);
    check("tgt_done_level", done, 1);
    do_abort();
    check("tgt_abort_done", done, 0);
    check("tgt_abort_busy", busy, 0);

    // Rejected writes/starts while armed, then gaps and abort on last bit.
    configure(8'b0000_1011, 4'd4, 1'b1, 8'd0, 1'b1);
    configure(8'b0000_0000, 4'd4, 1'b0, 8'd0, 1'b0);
    check("armed_cfg_err", err, 1);
    check("armed_cfg_busy", busy, 1);
    start = 1'b1; cycle(); start = 1'b0;
    check("armed_start_no_err", err, 0);
    check("armed_start_busy", busy, 1);
    send(1'b1);
    send(1'b0);
    x = 1'b1; cycle();
    check("gap1_match", match, 0);
    send(1'b1);
    x = 1'b0; cycle(); cycle();
    check("gap2_match", match, 0);
    send(1'b1);
    check("gap_match", match, 1);
    check("gap_cnt", match_cnt, 1);
    send(1'b0);
    send(1'b1);
    abort = 1'b1; x_valid = 1'b1; x = 1'b1;
    cycle();
    abort = 1'b0; x_valid = 1'b0;
    check("abort_bit_match", match, 0);
    check("abort_busy", busy, 0);
    check("abort_ready", x_ready, 0);
    check("abort_cnt", match_cnt, 1);
    cycle();
    check("abort_match_late", match, 0);

    // Counter saturation with pattern 11, overlap on: 299 matches from 300 ones.
    configure(8'b0000_0011, 4'd2, 1'b1, 8'd0, 1'b1);
    x_valid = 1'b1; x = 1'b1;
    for (int i = 0; i < 300; i++) cycle();
    x_valid = 1'b0;
    cycle();
    check("sat_cnt", match_cnt, 255);
    check("sat_busy", busy, 1);

    // Async reset while armed; config is lost afterwards.
    #2 rst = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_ready", x_ready, 0);
    check("arst_cnt", match_cnt, 0);
    check("arst_match", match, 0);
    check("arst_done", done, 0);
    check("arst_err", err, 0);
    cycle();
    rst = 1'b1;
    start = 1'b1; cycle(); start = 1'b0;
    check("post_rst_start_err", err, 1);
    check("post_rst_start_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
